// File: rtl/microcode_sequencer.sv
// Multi-cycle microcode sequencer: walks FETCH/DECODE/EXEC/MEM/WB/NEXT per opcode
// and drives a registered control word, instruction-retired pulse and counter.
module microcode_sequencer #(
  parameter int CTRL_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [5:0]            opcode,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [2:0]            state,
  output logic                  instr_done,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_NEXT   = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_LW  = 6'd0;
  localparam logic [5:0] OP_SW  = 6'd1;
  localparam logic [5:0] OP_R   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd3;
  localparam logic [5:0] OP_JMP = 6'd4;

  localparam logic [10:0] EIP_INC   = 11'h001;
  localparam logic [10:0] REGDST    = 11'h002;
  localparam logic [10:0] JUMP      = 11'h004;
  localparam logic [10:0] BRANCH    = 11'h008;
  localparam logic [10:0] MEMREAD   = 11'h010;
  localparam logic [10:0] MEMTOREG  = 11'h020;
  localparam logic [10:0] ALUOP_BEQ = 11'h040;
  localparam logic [10:0] ALUOP_R   = 11'h080;
  localparam logic [10:0] MEMWRITE  = 11'h100;
  localparam logic [10:0] ALUSRC    = 11'h200;
  localparam logic [10:0] REGWRITE  = 11'h400;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [5:0]             ir_op_q, ir_op_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic                   instr_done_q, instr_done_d;
  logic                   halted_q, halted_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [10:0]            word_s;

  // Next-state, opcode capture and retire counter
  always_comb begin
    state_d = state_q;
    ir_op_d = ir_op_q;
    count_d = count_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          state_d = S_DECODE;
          ir_op_d = opcode;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (ir_op_q)
          OP_LW, OP_SW, OP_R, OP_BEQ: state_d = S_EXEC;
          OP_JMP:                     state_d = S_NEXT;
          default:                    state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        case (ir_op_q)
          OP_LW, OP_R: state_d = S_WB;
          OP_SW:       state_d = S_MEM;
          default:     state_d = S_NEXT;
        endcase
      end
      S_MEM, S_WB: state_d = S_NEXT;
      S_NEXT: begin
        state_d = S_FETCH;
        count_d = count_q + CNT_ONE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Control word for the state being entered, so ctrl is a pure flop output
  always_comb begin
    word_s = 11'h000;
    case (state_d)
      S_EXEC: begin
        case (ir_op_q)
          OP_LW:   word_s = ALUSRC | MEMREAD | MEMTOREG;
          OP_SW:   word_s = ALUSRC;
          OP_R:    word_s = REGDST | ALUOP_R;
          OP_BEQ:  word_s = BRANCH | ALUOP_BEQ;
          default: word_s = 11'h000;
        endcase
      end
      S_WB: begin
        case (ir_op_q)
          OP_LW:   word_s = ALUSRC | MEMREAD | MEMTOREG | REGWRITE;
          OP_R:    word_s = REGDST | ALUOP_R | REGWRITE;
          default: word_s = 11'h000;
        endcase
      end
      S_MEM: word_s = ALUSRC | MEMWRITE;
      S_NEXT: begin
        case (ir_op_q)
          OP_BEQ:  word_s = BRANCH | ALUOP_BEQ | EIP_INC;
          OP_JMP:  word_s = JUMP | EIP_INC;
          default: word_s = EIP_INC;
        endcase
      end
      default: word_s = 11'h000;
    endcase
    ctrl_d       = CTRL_WIDTH'(word_s);
    instr_done_d = (state_d == S_NEXT);
    halted_d     = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      ir_op_q      <= 6'd0;
      ctrl_q       <= '0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ir_op_q      <= ir_op_d;
      ctrl_q       <= ctrl_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  assign ctrl        = ctrl_q;
  assign state       = state_q;
  assign instr_done  = instr_done_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: per-instruction expected traces from the opcode table, random
// run/opcode noise, async reset, HALT, and counter wrap on a narrow second instance.
module tb_microcode_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0;
  logic [5:0] opcode = 6'd0;

  logic [10:0] ctrl;
  logic [2:0]  state;
  logic        instr_done, halted;
  logic [15:0] instr_count;

  logic [11:0] ctrl_n;
  logic [2:0]  state_n;
  logic        instr_done_n, halted_n;
  logic [3:0]  instr_count_n;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned m_count = 0;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .ctrl(ctrl), .state(state), .instr_done(instr_done),
    .halted(halted), .instr_count(instr_count)
  );

  microcode_sequencer #(.CTRL_WIDTH(12), .CNT_WIDTH(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .ctrl(ctrl_n), .state(state_n), .instr_done(instr_done_n),
    .halted(halted_n), .instr_count(instr_count_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] est, input logic [10:0] ectl);
    chk({tag, ".state"},  32'(state), 32'(est));
    chk({tag, ".ctrl"},   32'(ctrl), 32'(ectl));
    chk({tag, ".done"},   32'(instr_done), 32'(ectl[0]));
    chk({tag, ".halted"}, 32'(halted), 32'(est == 3'd7));
    chk({tag, ".count"},  32'(instr_count), 32'(m_count[15:0]));
    chk({tag, ".n_state"}, 32'(state_n), 32'(est));
    chk({tag, ".n_ctrl"},  32'(ctrl_n), 32'({1'b0, ectl}));
    chk({tag, ".n_flags"}, 32'({instr_done_n, halted_n}), 32'({ectl[0], est == 3'd7}));
    chk({tag, ".n_count"}, 32'(instr_count_n), 32'(m_count[3:0]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles following DECODE for each opcode
  function automatic int n_after(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd2: return 3;
      6'd3:             return 2;
      default:          return 1;
    endcase
  endfunction

  // {state, ctrl} expected k cycles after DECODE
  function automatic logic [13:0] exp_at(input logic [5:0] op, input int k);
    logic [13:0] t [3];
    t[0] = 14'h0; t[1] = 14'h0; t[2] = 14'h0;
    case (op)
      6'd0: begin t[0] = {3'd2, 11'h230}; t[1] = {3'd4, 11'h630}; t[2] = {3'd5, 11'h001}; end
      6'd1: begin t[0] = {3'd2, 11'h200}; t[1] = {3'd3, 11'h300}; t[2] = {3'd5, 11'h001}; end
      6'd2: begin t[0] = {3'd2, 11'h082}; t[1] = {3'd4, 11'h482}; t[2] = {3'd5, 11'h001}; end
      6'd3: begin t[0] = {3'd2, 11'h048}; t[1] = {3'd5, 11'h049}; end
      6'd4: begin t[0] = {3'd5, 11'h005}; end
      default: t[0] = {3'd7, 11'h000};
    endcase
    return t[k];
  endfunction

  // mode 0: random run/opcode noise, 1: run=1 and opcode held, 2: run=0 after issue
  task automatic do_instr(input logic [5:0] op, input int mode);
    logic [13:0] e;
    run = 1'b1;
    opcode = op;
    step();
    chk_all($sformatf("op%0d.decode", op), 3'd1, 11'h000);
    for (int k = 0; k < n_after(op); k++) begin
      if (mode == 0) begin
        run = 1'($urandom_range(0, 1));
        opcode = 6'($urandom);
      end else if (mode == 2) begin
        run = 1'b0;
        opcode = 6'($urandom);
      end else begin
        run = 1'b1;
      end
      step();
      e = exp_at(op, k);
      chk_all($sformatf("op%0d.c%0d", op, k), e[13:11], e[10:0]);
    end
    if (op <= 6'd4) begin
      run = (mode == 1) ? 1'b1 : 1'b0;
      m_count++;
      step();
      chk_all($sformatf("op%0d.fetch", op), 3'd0, 11'h000);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      opcode = 6'($urandom);
      step();
      chk_all("idle", 3'd0, 11'h000);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_all("reset", 3'd0, 11'h000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_all("post_reset", 3'd0, 11'h000);

    do_instr(6'd0, 1);
    for (int op = 1; op <= 4; op++) do_instr(6'(op), 0);
    chk("count_after_jmp", 32'(instr_count), 32'd5);
    idle(10);
    do_instr(6'd0, 2);

    for (int i = 0; i < 40; i++) begin
      do_instr(6'($urandom_range(0, 4)), 0);
      idle($urandom_range(0, 2));
    end

    // Async reset in the middle of SW's memwrite cycle
    run = 1'b1; opcode = 6'd1;
    step(); chk_all("sw.decode", 3'd1, 11'h000);
    step(); chk_all("sw.exec", 3'd2, 11'h200);
    step(); chk_all("sw.mem", 3'd3, 11'h300);
    run = 1'b0;
    #2 rst_n = 1'b0;
    m_count = 0;
    #1 chk_all("async_rst", 3'd0, 11'h000);
    step(); chk_all("rst_held", 3'd0, 11'h000);
    @(negedge clk) rst_n = 1'b1;
    step(); chk_all("rst_release", 3'd0, 11'h000);
    do_instr(6'd1, 0);
    do_instr(6'd3, 0);

    // Illegal opcode halts until reset
    do_instr(6'h3F, 0);
    for (int i = 0; i < 22; i++) begin
      run = 1'b1;
      opcode = 6'($urandom_range(0, 4));
      step();
      chk_all("halt", 3'd7, 11'h000);
    end
    #2 rst_n = 1'b0;
    m_count = 0;
    #1 chk_all("halt_rst", 3'd0, 11'h000);
    run = 1'b0;
    #3 rst_n = 1'b1;
    step(); chk_all("halt_exit", 3'd0, 11'h000);
    do_instr(6'd2, 0);
    do_instr(6'd4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
